// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_CNT_WIDTH_DEFAULT = 32;

    function automatic logic [1:0] occupancy_of(input pipe_state_e state);
        case (state)
            PS_ONE:  occupancy_of = 2'd1;
            PS_TWO:  occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with flush/stall and optional statistics
// counters (enabled by defining PIPE_STAGE_SKID_STATS_EN).
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 200,
    parameter int CNT_WIDTH     = PIPE_CNT_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [1:0]               occupancy,
    output logic [CNT_WIDTH-1:0]     backpressure_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    pipe_state_e              state_reg, state_next;
    logic [PAYLOAD_WIDTH-1:0] main_reg, main_next;
    logic [PAYLOAD_WIDTH-1:0] skid_reg, skid_next;
    logic [1:0]               occupancy_reg;
    logic                     in_fire, out_fire;

    // Reset gates both handshakes so a reset never completes a transfer.
    assign in_ready  = !stall && !flush && !reset && (state_reg != PS_TWO);
    assign out_valid = (state_reg != PS_EMPTY) && !stall && !flush && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = PS_EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end else begin
            // Stall forces both fires low, so every branch below holds.
            case (state_reg)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_next  = in_payload;
                        state_next = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_payload;
                    end else if (in_fire) begin
                        skid_next  = in_payload;
                        state_next = PS_TWO;
                    end else if (out_fire) begin
                        state_next = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (out_fire) begin
                        main_next  = skid_reg;
                        state_next = PS_ONE;
                    end
                end
                default: begin
                    state_next = PS_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= PS_EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            occupancy_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            occupancy_reg <= occupancy_of(state_next);
        end
    end

    assign out_payload = main_reg;
    assign occupancy   = occupancy_reg;

`ifdef PIPE_STAGE_SKID_STATS_EN
    pipe_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_backpressure_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (out_valid && !out_ready),
        .count(backpressure_cnt)
    );

    pipe_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_bubble_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (!out_valid && !reset),
        .count(bubble_cnt)
    );
`else
    assign backpressure_cnt = '0;
    assign bubble_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (counter checks follow
// PIPE_STAGE_SKID_STATS_EN).
module tb_pipe_stage_skid;

    localparam int PW = 200;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset, flush, stall, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [PW-1:0] in_payload, out_payload;
    logic [1:0]    occupancy;
    logic [CW-1:0] backpressure_cnt, bubble_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PAYLOAD_WIDTH(PW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .stall           (stall),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_payload      (in_payload),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_payload     (out_payload),
        .occupancy       (occupancy),
        .backpressure_cnt(backpressure_cnt),
        .bubble_cnt      (bubble_cnt)
    );

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CW-1:0] exp_bp2, exp_bp5, exp_bub;
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_payload = '0;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_payload", out_payload, 0);
        check("rst_bp_cnt", backpressure_cnt, 0);
        check("rst_bub_cnt", bubble_cnt, 0);
        reset = 1'b0;
        tick();

        // Single entry, one-cycle latency
        in_valid = 1'b1; in_payload = 'hA5; out_ready = 1'b1;
        #1 check("a5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check("a5_out_valid", out_valid, 1);
        check("a5_payload", out_payload, 'hA5);
        check("a5_occ", occupancy, 1);
        tick();
        check("a5_drained_occ", occupancy, 0);
        check("a5_drained_valid", out_valid, 0);

        // Back-to-back stream 1..8
        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8); in_payload = PW'(i);
            #1;
            if (i >= 2) begin
                check($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
                check($sformatf("stream_data_%0d", i - 1), out_payload, PW'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        #1 check("stream_end_occ", occupancy, 0);

        // Fill the skid, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 'h11; tick();
        in_payload = 'h22; tick();
        in_valid = 1'b0;
        #1;
        check("full_occ", occupancy, 2);
        check("full_in_ready", in_ready, 0);
        check("full_head", out_payload, 'h11);
        out_ready = 1'b1;
        #1 check("drain_first", out_payload, 'h11);
        tick();
        check("drain_second", out_payload, 'h22);
        check("drain_occ1", occupancy, 1);
        tick();
        check("drain_occ0", occupancy, 0);

        // Flush beats stall and a simultaneous push
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 'h33; tick();
        in_payload = 'h44; tick();
        flush = 1'b1; stall = 1'b1; in_payload = 'h55;
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        tick();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_occ", occupancy, 0);
        check("flush_out_valid_after", out_valid, 0);
        check("flush_payload_zero", out_payload, 0);
        in_valid = 1'b1; in_payload = 'h66; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        #1 check("post_flush_data", out_payload, 'h66);
        tick();

        // Stall holds a single entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 'h77; tick();
        in_payload = 'h88; stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_out_valid_%0d", c), out_valid, 0);
            check($sformatf("stall_in_ready_%0d", c), in_ready, 0);
            out_ready = 1'b1;
            tick();
        end
        check("stall_occ", occupancy, 1);
        stall = 1'b0; in_valid = 1'b0;
        #1;
        check("stall_release_valid", out_valid, 1);
        check("stall_release_data", out_payload, 'h77);
        tick();
        check("stall_drained_occ", occupancy, 0);

        // Reset during a pending transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 'h99; tick();
        in_valid = 1'b0; reset = 1'b1; out_ready = 1'b1;
        #1 check("midrst_out_valid", out_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_occ", occupancy, 0);
        check("midrst_payload", out_payload, 0);
        tick();

        // Backpressure saturation with a 2-bit counter
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = 'hAB; tick();
        in_valid = 1'b0;
        tick(); tick();
`ifdef PIPE_STAGE_SKID_STATS_EN
        exp_bp2 = 2'd2; exp_bp5 = 2'd3; exp_bub = 2'd2;
`else
        exp_bp2 = 2'd0; exp_bp5 = 2'd0; exp_bub = 2'd0;
`endif
        check("bp_cnt_2", backpressure_cnt, exp_bp2);
        tick(); tick(); tick();
        check("bp_cnt_sat", backpressure_cnt, exp_bp5);
        check("bubble_cnt", bubble_cnt, exp_bub);
        check("bp_data_held", out_payload, 'hAB);
        out_ready = 1'b1;
        tick();
        check("bp_drained_occ", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
